par_frame_tx: RTL and testbench
===============================

// Module: par_frame_tx
// PURPOSE
//  Sequencer around the xor parity function: accepts parallel words on a
//  valid/ready handshake, shifts each word out serially LSB-first and appends
//  one parity bit (even or odd, chosen per word). Feeds serial links that
//  need a parity-framed bit stream.
// PARAMETERS
//  DATA_W   8   data bits per frame (>=2)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-high
//  in_valid   in   1       in_data/in_odd valid
//  in_data    in   DATA_W  word to send
//  in_odd     in   1       1 = odd parity, 0 = even parity for this word
//  in_ready   out  1       block can accept a word this cycle
//  ser_valid  out  1       ser_data carries a frame bit
//  ser_data   out  1       serial bit (data LSB first, then parity)
//  ser_last   out  1       ser_data is the parity bit (last bit of frame)
//  busy       out  1       frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async): state=IDLE; ser_valid=0, ser_data=0, ser_last=0, busy=0,
//    shift reg, bit counter and parity accumulator cleared. in_ready=0 while rst=1.
//  - FSM: IDLE -> DATA on accept; DATA -> PAR after DATA_W bits;
//    PAR -> DATA if a new word is accepted that cycle, else PAR -> IDLE.
//  - in_ready = (state==IDLE || state==PAR) && !rst (combinational from state).
//  - Accept = in_valid && in_ready. On accept: load in_data, latch in_odd,
//    clear parity accumulator, clear bit counter. in_data/in_odd ignored otherwise.
//  - DATA: one bit per cycle, registered: ser_valid=1, ser_last=0,
//    ser_data=shift[0]; accumulator ^= shift[0]. First data bit appears the
//    cycle after accept (latency 1). Counter 0..DATA_W-1, no wrap beyond.
//  - PAR: one cycle, ser_valid=1, ser_last=1,
//    ser_data = (XOR of all DATA_W bits) ^ odd_q.
//    Even: total ones in frame (data+parity) even; odd: total ones odd.
//  - Frame = DATA_W+1 serial cycles. Back-to-back accept in PAR gives
//    gap-free stream; accept in IDLE gives a 1-cycle ser_valid=0 bubble.
//  - IDLE: ser_valid=0, ser_last=0, ser_data=0.
//  - No backpressure on serial side: bits are never stalled.
//  - Reset mid-frame: frame is dropped, outputs return to reset values
//    immediately; no partial parity bit is emitted afterwards.
//  - in_valid held high with changing data while in DATA: no effect.
// CONFIGURATION
//  PARFRM_ERRINJ_EN defined: extra input port `in_err_inj` (1 bit), sampled
//    with in_data on accept; when 1 the parity bit of that frame is inverted
//    (deliberate error for downstream checker tests). Data bits unaffected.
//  Not defined: port absent, parity bit always correct.
// TESTING (DATA_W=8)
//  1. rst pulse mid-idle -> in_ready=0 during rst, all outputs 0; in_ready=1 next cycle.
//  2. 8'hA5, in_odd=0 -> ser_data 1,0,1,0,0,1,0,1 then parity 0 with ser_last=1.
//  3. 8'h07, in_odd=0 -> parity 1; 8'h07, in_odd=1 -> parity 0.
//  4. 8'h01 then 8'hFF (in_odd=1) held valid -> second accept in PAR cycle,
//     18 consecutive ser_valid=1 cycles, parities 0 then 1.
//  5. rst asserted after 4th bit of 8'h3C -> outputs 0 same cycle, no parity
//     bit emitted; next word 8'h00 even -> eight 0s then parity 0.
//  6. PARFRM_ERRINJ_EN: 8'hA5, in_odd=0, in_err_inj=1 -> parity bit 1;
//     next frame with in_err_inj=0 -> correct parity.

Source files
------------

// File: rtl/par_frame_tx.sv
// par_frame_tx: parity-framing serialiser.
// Takes parallel words on a valid/ready handshake.
// Shifts each word out LSB-first, one bit per clock.
// Appends one parity bit per frame; even or odd parity is chosen per word.
//
// Optional feature macro: PARFRM_ERRINJ_EN
//   When defined, an extra input in_err_inj is sampled with in_data on accept.
//   A 1 inverts the parity bit of that frame.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_data/in_odd valid
//   in_data    word to send (DATA_W bits)
//   in_odd     1 = odd parity, 0 = even parity for this word
//   in_err_inj (PARFRM_ERRINJ_EN only) invert this frame's parity bit
//   in_ready   block can accept a word this cycle
//   ser_valid  ser_data carries a frame bit
//   ser_data   serial bit (data LSB first, then parity)
//   ser_last   ser_data is the parity bit
//   busy       frame in progress
module par_frame_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_odd,
`ifdef PARFRM_ERRINJ_EN
    input  logic              in_err_inj,
`endif
    output logic              in_ready,
    output logic              ser_valid,
    output logic              ser_data,
    output logic              ser_last,
    output logic              busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              odd_q, odd_d;
    logic              inj_q, inj_d;
    logic              accept;
    logic              inj_in;

`ifdef PARFRM_ERRINJ_EN
    assign inj_in = in_err_inj;
`else
    assign inj_in = 1'b0;
`endif

    // Ready depends on rst directly so it drops in the same cycle as reset.
    assign in_ready = ((state_q == StIdle) || (state_q == StPar)) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        odd_d   = odd_q;
        inj_d   = inj_q;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StData;
            end
            StData: begin
                shift_d = {1'b0, shift_q[DATA_W-1:1]};
                acc_d   = acc_q ^ shift_q[0];
                if (cnt_q == CNT_LAST) begin
                    state_d = StPar;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPar: begin
                state_d = accept ? StData : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new word overrides whatever the current state would have done.
        if (accept) begin
            shift_d = in_data;
            odd_d   = in_odd;
            inj_d   = inj_in;
            acc_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            odd_q   <= odd_d;
            inj_q   <= inj_d;
        end
    end

    // Outputs decode registered state only.
    // They follow the async reset immediately.
    always_comb begin
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        ser_data  = 1'b0;
        unique case (state_q)
            StData: begin
                ser_valid = 1'b1;
                ser_data  = shift_q[0];
            end
            StPar: begin
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                // acc_q holds the XOR of all data bits here.
                ser_data  = acc_q ^ odd_q ^ inj_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_par_frame_tx.sv
// Self-checking bench for par_frame_tx (DATA_W = 8).
module tb_par_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_odd;
    logic       in_err_inj;
    logic       in_ready, ser_valid, ser_data, ser_last, busy;

    int checks = 0;
    int errors = 0;

    par_frame_tx #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_odd    (in_odd),
`ifdef PARFRM_ERRINJ_EN
        .in_err_inj(in_err_inj),
`endif
        .in_ready  (in_ready),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_out(input string name);
        chk({name, " ser_valid"}, ser_valid, 0);
        chk({name, " ser_data"},  ser_data,  0);
        chk({name, " ser_last"},  ser_last,  0);
        chk({name, " busy"},      busy,      0);
    endtask

    // Called just after a negedge with the DUT idle.
    // Returns just after the negedge on which the DUT is idle again.
    task automatic send_frame(input string name, input logic [7:0] d, input logic odd,
                              input logic err, input logic exp_par);
        in_valid   = 1'b1;
        in_data    = d;
        in_odd     = odd;
        in_err_inj = err;
        chk({name, " in_ready idle"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = ~d;
        in_odd     = ~odd;
        in_err_inj = ~err;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({name, " data valid"}, ser_valid, 1);
            chk({name, " data bit"},   ser_data,  d[i]);
            chk({name, " data last"},  ser_last,  0);
            chk({name, " busy"},       busy,      1);
        end
        @(negedge clk);
        chk({name, " par valid"}, ser_valid, 1);
        chk({name, " par bit"},   ser_data,  exp_par);
        chk({name, " par last"},  ser_last,  1);
        @(negedge clk);
        chk_idle_out({name, " after"});
        chk({name, " ready after"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w0, w1;

        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h01, 1'b0, 1'b1};
        vecs[6] = '{8'h3C, 1'b1, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 1'b0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_odd     = 1'b0;
        in_err_inj = 1'b0;
        #2;
        chk("reset in_ready", in_ready, 0);
        chk_idle_out("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post reset ready", in_ready, 1);
        @(negedge clk);

        // Reset pulse while idle.
        rst = 1'b1;
        #1;
        chk("idle rst ready", in_ready, 0);
        chk_idle_out("idle rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle rst ready after", in_ready, 1);

        for (int v = 0; v < 8; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].odd, 1'b0, vecs[v].par);
        end

        // Back-to-back: 8'h01 then 8'hFF, both odd, valid held high.
        // Data changes during DATA must be ignored.
        w0 = 8'h01;
        w1 = 8'hFF;
        in_valid = 1'b1;
        in_data  = w0;
        in_odd   = 1'b1;
        @(posedge clk);
        #1;
        in_data = w1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("b2b valid", ser_valid, 1);
            if (k < 8) begin
                chk("b2b f0 bit",   ser_data, w0[k]);
                chk("b2b f0 last",  ser_last, 0);
                chk("b2b f0 ready", in_ready, 0);
            end else if (k == 8) begin
                chk("b2b f0 par",   ser_data, 0);
                chk("b2b f0 plast", ser_last, 1);
                chk("b2b par ready", in_ready, 1);
            end else if (k < 17) begin
                chk("b2b f1 bit",  ser_data, w1[k-9]);
                chk("b2b f1 last", ser_last, 0);
                in_valid = 1'b0;
            end else begin
                chk("b2b f1 par",   ser_data, 1);
                chk("b2b f1 plast", ser_last, 1);
            end
        end
        @(negedge clk);
        chk_idle_out("b2b end");

        // Reset after the 4th bit of 8'h3C: frame dropped, no parity bit.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_odd   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst mid bit", ser_data, w0[0] & 1'b0 | in_data[i]);
        end
        rst = 1'b1;
        #1;
        chk("rst mid ready", in_ready, 0);
        chk_idle_out("rst mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_out("rst mid quiet");
        end
        send_frame("after rst 00", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef PARFRM_ERRINJ_EN
        send_frame("errinj on",  8'hA5, 1'b0, 1'b1, 1'b1);
        send_frame("errinj off", 8'hA5, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
